// File: rtl/fft_pkg.sv
// Shared helpers for the FFT datapath stages: phase encoding, ceil-log2 and
// two's-complement saturation.
package fft_pkg;

    // Which half of a frame the stage is in: FILL loads the delay line,
    // BFLY combines the delay-line head with the incoming sample.
    typedef enum logic {
        PH_FILL = 1'b0,
        PH_BFLY = 1'b1
    } phase_e;

    // Ceiling log2, intended for elaboration-time constants.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clamp a sign-extended value into the signed range of 'width' bits.
    // The caller compares the result with the input to detect clipping.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/sdf_delay.sv
// Feedback delay line of a single-path delay-feedback stage: an enabled
// shift register of DEPTH complex words, each WIDTH*2 bits ({re, im}).
module sdf_delay #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2*WIDTH-1:0]   din,
    output logic [2*WIDTH-1:0]   head
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    // Shift one position per enabled cycle; the oldest entry is the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign head = mem[DEPTH-1];

endmodule

// File: rtl/sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage (BF2I / BF2II).
// Valid/ready contract: there is no back-pressure. A sample is accepted on
// every rising edge where in_valid is high; out_valid qualifies out_re/out_im
// for exactly the cycle after an accepted input once the delay line is primed.
module sdf_bf_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int MODE  = 0,
    parameter int SCALE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    ovf
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] LAST     = CW'((MODE == 1 ? 4 : 2) * DEPTH - 1);
    localparam logic [CW-1:0] PRIME_AT = CW'(DEPTH - 1);
    localparam logic signed [WIDTH+1:0] ONE = {{(WIDTH+1){1'b0}}, 1'b1};

    logic [CW-1:0]          cnt;
    logic                   primed;
    phase_e                 phase;
    logic                   twiddle;
    logic [2*WIDTH-1:0]     head;
    logic [2*WIDTH-1:0]     dl_in;
    logic signed [WIDTH-1:0] head_re;
    logic signed [WIDTH-1:0] head_im;
    logic signed [WIDTH:0]   x_re;
    logic signed [WIDTH:0]   x_im;
    logic signed [WIDTH+1:0] sum_re;
    logic signed [WIDTH+1:0] sum_im;
    logic signed [WIDTH+1:0] dif_re;
    logic signed [WIDTH+1:0] dif_im;
    logic [WIDTH:0]          p_sum_re;
    logic [WIDTH:0]          p_sum_im;
    logic [WIDTH:0]          p_dif_re;
    logic [WIDTH:0]          p_dif_im;
    logic signed [WIDTH-1:0] out_re_next;
    logic signed [WIDTH-1:0] out_im_next;
    logic                    clip;

    // Optional halving with round-half-up, then saturation to WIDTH bits.
    // Returns {clipped, value}.
    function automatic logic [WIDTH:0] post(input logic signed [WIDTH+1:0] s);
        logic signed [WIDTH+1:0] r;
        logic signed [63:0]      ext;
        logic signed [63:0]      sat;
        r   = (SCALE != 0) ? ((s + ONE) >>> 1) : s;
        ext = {{(62-WIDTH){r[WIDTH+1]}}, r};
        sat = saturate(ext, WIDTH);
        return {(sat != ext), sat[WIDTH-1:0]};
    endfunction

    assign phase   = phase_e'(cnt[AW]);
    assign twiddle = (MODE == 1) && cnt[AW+1];
    assign head_re = head[2*WIDTH-1:WIDTH];
    assign head_im = head[WIDTH-1:0];

    sdf_delay #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .din   (dl_in),
        .head  (head)
    );

    // Butterfly datapath: twiddle, sum/difference, post-processing, and
    // the FILL/BFLY routing of output and delay-line write data.
    always_comb begin
        x_re        = {in_re[WIDTH-1], in_re};
        x_im        = {in_im[WIDTH-1], in_im};
        if (twiddle) begin
            // -j * (re + j*im) = im - j*re
            x_re = {in_im[WIDTH-1], in_im};
            x_im = -{in_re[WIDTH-1], in_re};
        end
        sum_re   = {{2{head_re[WIDTH-1]}}, head_re} + {x_re[WIDTH], x_re};
        sum_im   = {{2{head_im[WIDTH-1]}}, head_im} + {x_im[WIDTH], x_im};
        dif_re   = {{2{head_re[WIDTH-1]}}, head_re} - {x_re[WIDTH], x_re};
        dif_im   = {{2{head_im[WIDTH-1]}}, head_im} - {x_im[WIDTH], x_im};
        p_sum_re = post(sum_re);
        p_sum_im = post(sum_im);
        p_dif_re = post(dif_re);
        p_dif_im = post(dif_im);

        out_re_next = head_re;
        out_im_next = head_im;
        dl_in       = {in_re, in_im};
        clip        = 1'b0;
        if (phase == PH_BFLY) begin
            out_re_next = p_sum_re[WIDTH-1:0];
            out_im_next = p_sum_im[WIDTH-1:0];
            dl_in       = {p_dif_re[WIDTH-1:0], p_dif_im[WIDTH-1:0]};
            clip        = p_sum_re[WIDTH] | p_sum_im[WIDTH] |
                          p_dif_re[WIDTH] | p_dif_im[WIDTH];
        end
    end

    // Frame counter, priming, sticky overflow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            primed    <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= in_valid & primed;
            if (in_valid) begin
                cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
                out_re <= out_re_next;
                out_im <= out_im_next;
                if (clip) begin
                    ovf <= 1'b1;
                end
                if (cnt == PRIME_AT) begin
                    primed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Bench for sdf_bf_stage: three configurations driven from one stimulus
// process; per-instance monitors pop expected outputs from queues.
module tb_sdf_bf_stage;

    logic clk;
    logic rst_n;

    // Instance A: BF2I, W=8, D=2, scaled
    logic              va, a_out_valid, a_ovf;
    logic signed [7:0] ra, ia, a_out_re, a_out_im;
    // Instance B: BF2II, W=8, D=1, scaled
    logic              vb, b_out_valid, b_ovf;
    logic signed [7:0] rb, ib, b_out_re, b_out_im;
    // Instance C: BF2I, W=8, D=1, unscaled (saturating)
    logic              vc, c_out_valid, c_ovf;
    logic signed [7:0] rc, ic, c_out_re, c_out_im;

    logic prev_va, prev_vb, prev_vc;

    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];
    logic [15:0] exp_q_c[$];

    int n_checks;
    int n_fail;

    sdf_bf_stage #(.WIDTH(8), .DEPTH(2), .MODE(0), .SCALE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_re(ra), .in_im(ia),
        .out_valid(a_out_valid), .out_re(a_out_re), .out_im(a_out_im), .ovf(a_ovf)
    );

    sdf_bf_stage #(.WIDTH(8), .DEPTH(1), .MODE(1), .SCALE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_re(rb), .in_im(ib),
        .out_valid(b_out_valid), .out_re(b_out_re), .out_im(b_out_im), .ovf(b_ovf)
    );

    sdf_bf_stage #(.WIDTH(8), .DEPTH(1), .MODE(0), .SCALE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_re(rc), .in_im(ic),
        .out_valid(c_out_valid), .out_re(c_out_re), .out_im(c_out_im), .ovf(c_ovf)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        prev_va <= va;
        prev_vb <= vb;
        prev_vc <= vc;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, req, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of stimulus on instance sel; when the sample is
    // accepted and has_exp is set, queue its expected output.
    task automatic send(input int sel, input logic v, input int re, input int im,
                        input logic has_exp, input int ere, input int eim);
        logic [7:0] er;
        logic [7:0] ei;
        logic [7:0] dr;
        logic [7:0] di;
        @(negedge clk);
        er = ere[7:0];
        ei = eim[7:0];
        dr = re[7:0];
        di = im[7:0];
        case (sel)
            0: begin va = v; ra = dr; ia = di; if (v && has_exp) exp_q_a.push_back({er, ei}); end
            1: begin vb = v; rb = dr; ib = di; if (v && has_exp) exp_q_b.push_back({er, ei}); end
            default: begin vc = v; rc = dr; ic = di; if (v && has_exp) exp_q_c.push_back({er, ei}); end
        endcase
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            va = 1'b0;
            vb = 1'b0;
            vc = 1'b0;
        end
    endtask

    // Reset pulse with output checks while reset is held.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_re", a_out_re, 0);
        check("rst_a_out_im", a_out_im, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_c_ovf", c_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [15:0] e;
        if (a_out_valid) begin
            check("a_valid_timing", prev_va, 1);
            if (exp_q_a.size() == 0) begin
                check("a_unexpected_valid", 1, 0);
            end else begin
                e = exp_q_a.pop_front();
                check("a_out_re", a_out_re, $signed(e[15:8]));
                check("a_out_im", a_out_im, $signed(e[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (b_out_valid) begin
            check("b_valid_timing", prev_vb, 1);
            if (exp_q_b.size() == 0) begin
                check("b_unexpected_valid", 1, 0);
            end else begin
                e = exp_q_b.pop_front();
                check("b_out_re", b_out_re, $signed(e[15:8]));
                check("b_out_im", b_out_im, $signed(e[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (c_out_valid) begin
            check("c_valid_timing", prev_vc, 1);
            if (exp_q_c.size() == 0) begin
                check("c_unexpected_valid", 1, 0);
            end else begin
                e = exp_q_c.pop_front();
                check("c_out_re", c_out_re, $signed(e[15:8]));
                check("c_out_im", c_out_im, $signed(e[7:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        va = 1'b0; ra = '0; ia = '0;
        vb = 1'b0; rb = '0; ib = '0;
        vc = 1'b0; rc = '0; ic = '0;

        // Reset state, during and after reset
        @(negedge clk);
        check("init_a_out_valid", a_out_valid, 0);
        check("init_a_out_re", a_out_re, 0);
        check("init_a_out_im", a_out_im, 0);
        check("init_a_ovf", a_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_a_out_valid", a_out_valid, 0);
        check("post_rst_b_out_re", b_out_re, 0);
        check("post_rst_c_ovf", c_ovf, 0);

        // BF2I contiguous: 10,20,30,40,0,0 -> 20,30,-10,-10
        send(0, 1, 10, 0, 0, 0, 0);
        send(0, 1, 20, 0, 0, 0, 0);
        send(0, 1, 30, 0, 1, 20, 0);
        send(0, 1, 40, 0, 1, 30, 0);
        send(0, 1, 0,  0, 1, -10, 0);
        send(0, 1, 0,  0, 1, -10, 0);
        idle(3);
        check("a_ovf_clean", a_ovf, 0);
        check("a_queue_drained_1", exp_q_a.size(), 0);

        // BF2I with a bubble between every accepted sample
        pulse_reset();
        send(0, 1, 10, 0, 0, 0, 0);   send(0, 0, 99, 55, 0, 0, 0);
        send(0, 1, 20, 0, 0, 0, 0);   send(0, 0, -7, 3, 0, 0, 0);
        send(0, 1, 30, 0, 1, 20, 0);  send(0, 0, 99, 55, 0, 0, 0);
        send(0, 1, 40, 0, 1, 30, 0);  send(0, 0, -7, 3, 0, 0, 0);
        send(0, 1, 0,  0, 1, -10, 0); send(0, 0, 99, 55, 0, 0, 0);
        send(0, 1, 0,  0, 1, -10, 0);
        idle(3);
        check("a_queue_drained_2", exp_q_a.size(), 0);

        // BF2II: twiddle on the second butterfly of each frame
        send(1, 1, 0,  0, 0, 0, 0);
        send(1, 1, 0,  0, 1, 0, 0);
        send(1, 1, 4,  0, 1, 0, 0);
        send(1, 1, 0,  8, 1, 6, 0);
        send(1, 1, 10, 6, 1, -2, 0);
        send(1, 1, 2,  4, 1, 6, 5);
        idle(3);
        check("b_ovf_clean", b_ovf, 0);
        check("b_queue_drained", exp_q_b.size(), 0);

        // Unscaled saturation, positive and negative, sticky ovf
        send(2, 1, 100,  0, 0, 0, 0);
        send(2, 1, 100,  0, 1, 127, 0);
        idle(1);
        check("c_ovf_set", c_ovf, 1);
        send(2, 1, 1,    0, 1, 0, 0);
        send(2, 1, 2,    0, 1, 3, 0);
        idle(2);
        check("c_ovf_sticky", c_ovf, 1);
        send(2, 1, -100, 0, 1, -1, 0);
        send(2, 1, -100, 0, 1, -128, 0);
        idle(3);
        check("c_ovf_still_set", c_ovf, 1);
        check("c_queue_drained", exp_q_c.size(), 0);

        // Mid-frame reset on A: clears state and restarts the frame
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("c_ovf_cleared", c_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 1, 10, 0, 0, 0, 0);
        send(0, 1, 20, 0, 0, 0, 0);
        send(0, 1, 30, 0, 1, 20, 0);
        idle(2);
        pulse_reset();
        send(0, 1, 10, 0, 0, 0, 0);
        send(0, 1, 20, 0, 0, 0, 0);
        send(0, 1, 30, 0, 1, 20, 0);
        send(0, 1, 40, 0, 1, 30, 0);
        idle(3);
        check("a_queue_drained_3", exp_q_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdf_bf_stage.md
SDF_BF_STAGE -- requirements
Module: sdf_bf_stage

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each real/imag sample component, >=4.
REQ-002 Parameter DEPTH, default 8: feedback delay length in samples, power of two, >=1.
REQ-003 Parameter MODE, default 0: 0 = BF2I (plain butterfly); 1 = BF2II (butterfly with -j twiddle).
REQ-004 Parameter SCALE, default 1: 1 = sum/difference halved with round-half-up; 0 = unscaled, saturated.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  qualifies in_re/in_im; the stage advances only when high.
REQ-008 in_re, in_im  input  WIDTH each  signed input sample.
REQ-009 out_valid  output  1  qualifies out_re/out_im.
REQ-010 out_re, out_im  output  WIDTH each  signed output sample, registered.
REQ-011 ovf  output  1  sticky flag: any saturation event since reset.

Function
REQ-012 Sample counter cnt SHALL count accepted inputs modulo 2*DEPTH (MODE=0) or 4*DEPTH (MODE=1) and wrap to 0.
REQ-013 FILL phase, cnt bit log2(DEPTH) = 0: the input SHALL enter the DEPTH-entry delay line, and the delay-line head SHALL be emitted unchanged.
REQ-014 BFLY phase, bit = 1: output = f(head + x) and the delay line SHALL take f(head - x), where x is the input after any twiddle.
REQ-015 MODE=1 BFLY samples with cnt bit log2(2*DEPTH) = 1 SHALL use x = -j*in: (re,im) -> (im, -re), computed at WIDTH+1 bits.
REQ-016 Intermediate sums SHALL be WIDTH+2 bits signed.
REQ-017 SCALE=1: f(s) = (s+1)>>>1, then saturated to WIDTH.
REQ-018 SCALE=0: f(s) = s, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-019 Any clipping on either the output or the delay-line write SHALL set ovf.
REQ-020 Output registers SHALL update one clk after the accepted input; with in_valid low, the delay line, cnt and outputs SHALL hold.
REQ-021 out_valid SHALL equal in_valid registered one cycle, gated by primed.
REQ-022 primed SHALL set after the first DEPTH accepted inputs following reset, so the initial FILL zeros are never flagged valid.
REQ-023 Latency SHALL be DEPTH accepted samples plus 1 clk.

Reset
REQ-024 rst_n low SHALL immediately clear cnt, primed, ovf, out_valid, out_re, out_im and every delay-line entry to 0.
REQ-025 After a mid-frame reset, the next accepted input SHALL be treated as sample 0 of a new frame.

Structure
REQ-026 The shared package fft_pkg SHALL hold the clog2 function and the saturate(value, WIDTH) helper; no block-local copies.
REQ-027 The delay line SHALL be one sub-module, sdf_delay: WIDTH*2-bit enabled shift register, parameter DEPTH, async active-low reset.

Verification
REQ-028 Reset check: rst_n low -> out_valid=0, out_re=out_im=0, ovf=0 during and after reset.
REQ-029 BF2I with W=8, D=2, S=1:
  - stimulus: contiguous re inputs 10,20,30,40,0,0 (im 0)
  - response: valid outputs re = 20,30,-10,-10.
REQ-030 Stall: same stimulus as REQ-029 with in_valid low on alternate cycles -> identical output sequence; out_valid high only one clk after each accepted input.
REQ-031 BF2II with W=8, D=1, M=1, S=1:
  - stimulus: inputs (0,0),(0,0),(4,0),(0,8)
  - response: fourth valid output = (6,0).
REQ-032 Saturation with W=8, D=1, S=0:
  - stimulus: inputs 100,100
  - response: output 127, ovf=1 and held until reset.
REQ-033 Mid-frame reset: pulse rst_n low after the third input -> outputs clear; next DEPTH inputs produce out_valid=0.
